tmds_decoder: RTL and testbench

Receive-side counterpart of `tmds_encoder`: takes a raw 10-bit TMDS word stream per channel at pixel rate, finds the word boundary by hunting for control tokens, and decodes the stream back to 8-bit video data, a 2-bit control value and a data-enable flag. Used as the loopback checker behind the HDMI output chain, one instance per channel (red, green, blue), on `clk_pixel`.

---
 rtl/tmds_pkg.sv | 33 +++
 rtl/tmds_word_decode.sv | 34 +++
 rtl/tmds_decoder.sv | 136 +++++++++++++
 tb/tb_tmds_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tmds_pkg : shared TMDS control tokens, receiver state, token lookup
// Rev 1.0
// ------------------------------------------------------------------
package tmds_pkg;

   localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
   localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
   localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
   localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

   typedef enum logic [0:0] {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } tmds_rx_state_t;

   // Returns {hit, control}; hit is 0 for any non-token word.
   function automatic logic [2:0] token_to_control(input logic [9:0] word);
      logic [2:0] res;
      res = 3'b000;
      case (word)
         TOKEN_C00: res = 3'b100;
         TOKEN_C01: res = 3'b101;
         TOKEN_C10: res = 3'b110;
         TOKEN_C11: res = 3'b111;
         default:   res = 3'b000;
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_word_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// tmds_word_decode : combinational 10b candidate -> token/control/data
// Rev 1.0
// ------------------------------------------------------------------
module tmds_word_decode
   import tmds_pkg::*;
(
   input  logic [9:0] cand_i,
   output logic       is_token_o,
   output logic [1:0] control_o,
   output logic [7:0] data_o
);

   logic [7:0] d;
   logic [7:0] dat;
   logic [2:0] tok;

   always_comb begin
      tok    = token_to_control(cand_i);
      d      = cand_i[9] ? ~cand_i[7:0] : cand_i[7:0];
      dat    = '0;
      dat[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         dat[i] = cand_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

   assign is_token_o = tok[2];
   assign control_o  = tok[1:0];
   assign data_o     = dat;

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// tmds_decoder : word aligner (control-token hunt) and TMDS decoder
// Rev 1.0
// ------------------------------------------------------------------
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int TOKEN_RUN    = 16,
   parameter int LOCK_TIMEOUT = 2048
)
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [9:0] tmds_in,
   output logic [7:0] data_out,
   output logic [1:0] control_out,
   output logic       de_out,
   output logic       locked_out,
   output logic [3:0] offset_out
);

   localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
   localparam int IDLE_W = $clog2(LOCK_TIMEOUT);
   localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(TOKEN_RUN - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(LOCK_TIMEOUT - 1);

   tmds_rx_state_t    state_q, state_d;
   logic [9:0]        prev_word_q;
   logic [3:0]        offset_q, offset_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [7:0]        data_q, data_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic              de_q, de_d;

   logic [19:0] window;
   logic [9:0]  cand;
   logic        is_token;
   logic [1:0]  dec_ctrl;
   logic [7:0]  dec_data;
   logic        timeout;
   logic [3:0]  slip_off;

   assign window = {tmds_in, prev_word_q};

   always_comb begin
      cand = window[9:0];
      for (int k = 1; k < 10; k++) begin
         if (offset_q == 4'(k)) begin
            cand = window[k +: 10];
         end
      end
   end

   tmds_word_decode u_word_decode (
      .cand_i     (cand),
      .is_token_o (is_token),
      .control_o  (dec_ctrl),
      .data_o     (dec_data)
   );

   assign timeout  = !is_token && (idle_q == IDLE_MAX);
   assign slip_off = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      run_d    = run_q;
      idle_d   = is_token ? '0 : idle_q + 1'b1;
      case (state_q)
         SEARCH: begin
            run_d = is_token ? run_q + 1'b1 : '0;
            if (is_token && (run_q == RUN_LAST)) begin
               state_d = LOCKED;
               run_d   = '0;
            end else if (timeout) begin
               offset_d = slip_off;
               run_d    = '0;
               idle_d   = '0;
            end
         end
         LOCKED: begin
            if (timeout) begin
               state_d  = SEARCH;
               offset_d = slip_off;
               run_d    = '0;
               idle_d   = '0;
            end
         end
         default: begin
            state_d = SEARCH;
         end
      endcase

      // Outputs follow the next state so the locking token is shown at once.
      de_d   = 1'b0;
      data_d = '0;
      ctrl_d = '0;
      if (state_d == LOCKED) begin
         de_d   = !is_token;
         data_d = is_token ? 8'h00 : dec_data;
         ctrl_d = is_token ? dec_ctrl : ctrl_q;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= SEARCH;
         prev_word_q <= '0;
         offset_q    <= '0;
         run_q       <= '0;
         idle_q      <= '0;
         data_q      <= '0;
         ctrl_q      <= '0;
         de_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_word_q <= tmds_in;
         offset_q    <= offset_d;
         run_q       <= run_d;
         idle_q      <= idle_d;
         data_q      <= data_d;
         ctrl_q      <= ctrl_d;
         de_q        <= de_d;
      end
   end

   assign data_out    = data_q;
   assign control_out = ctrl_q;
   assign de_out      = de_q;
   assign locked_out  = (state_q == LOCKED);
   assign offset_out  = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tmds_decoder : randomized self-checking bench for tmds_decoder
// Rev 1.0
// ------------------------------------------------------------------
module tb_tmds_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] tmds = '0;
   logic [7:0] data_o;
   logic [1:0] ctrl_o;
   logic       de_o;
   logic       locked_o;
   logic [3:0] offset_o;

   always #5 clk = ~clk;

   tmds_decoder #(
      .TOKEN_RUN    (16),
      .LOCK_TIMEOUT (2048)
   ) dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .tmds_in     (tmds),
      .data_out    (data_o),
      .control_out (ctrl_o),
      .de_out      (de_o),
      .locked_out  (locked_o),
      .offset_out  (offset_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                               10'b0101010100, 10'b1010101011};

   bit         bitq[$];
   bit         p_valid = 1'b0;
   bit         p_tok   = 1'b0;
   logic [1:0] p_ctrl  = '0;
   logic [7:0] p_byte  = '0;
   logic [1:0] exp_ctrl = '0;
   logic [3:0] exp_off  = '0;
   bit         chk_dec  = 1'b0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_tok_word(input logic [9:0] w);
      bit hit = 1'b0;
      for (int i = 0; i < 4; i++) if (tok_tab[i] == w) hit = 1'b1;
      return hit;
   endfunction

   // Any of the four XOR/XNOR x invert variants is a legal encoding;
   // pick one at random that does not alias a control token.
   function automatic logic [9:0] encode(input logic [7:0] b);
      logic [9:0] w = '0;
      logic [7:0] qm;
      logic [1:0] sel;
      int         start = int'($urandom_range(0, 3));
      for (int a = 0; a < 4; a++) begin
         sel   = 2'((start + a) % 4);
         qm[0] = b[0];
         for (int i = 1; i < 8; i++)
            qm[i] = sel[0] ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
         w = {sel[1], sel[0], sel[1] ? ~qm : qm};
         if (!is_tok_word(w)) break;
      end
      return w;
   endfunction

   // Transmit one word through the bit-delay line; the decoded output
   // visible after this edge belongs to the previously transmitted word.
   task automatic tx(input logic [9:0] w, input bit is_tok, input logic [1:0] c,
                     input logic [7:0] b);
      logic [9:0] rx;
      for (int i = 0; i < 10; i++) bitq.push_back(w[i]);
      for (int i = 0; i < 10; i++) rx[i] = bitq.pop_front();
      tmds = rx;
      @(posedge clk);
      #1;
      if (p_valid && p_tok) exp_ctrl = p_ctrl;
      if (chk_dec && p_valid) begin
         chk("locked", 16'(locked_o), 16'd1);
         chk("offset", 16'(offset_o), 16'(exp_off));
         chk("de", 16'(de_o), 16'(!p_tok));
         chk("data", 16'(data_o), 16'(p_tok ? 8'h00 : p_byte));
         chk("ctrl", 16'(ctrl_o), 16'(exp_ctrl));
      end
      p_valid = 1'b1;
      p_tok   = is_tok;
      p_ctrl  = c;
      p_byte  = b;
   endtask

   task automatic send_tok(input logic [1:0] c);
      tx(tok_tab[c], 1'b1, c, 8'h00);
   endtask

   task automatic send_byte(input logic [7:0] b);
      tx(encode(b), 1'b0, 2'b00, b);
   endtask

   task automatic set_delay(input int k);
      bitq.delete();
      for (int i = 0; i < k; i++) bitq.push_back(1'b0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_lock"}, 16'(locked_o), 16'd0);
      chk({tag, "_de"},   16'(de_o),     16'd0);
      chk({tag, "_data"}, 16'(data_o),   16'd0);
      chk({tag, "_ctrl"}, 16'(ctrl_o),   16'd0);
   endtask

   // All-zero words contain no token at any offset, so slips are periodic.
   task automatic hunt(input int slips, input int start_off);
      int off = start_off;
      for (int s = 0; s < slips; s++) begin
         repeat (2047) tx(10'd0, 1'b0, 2'b00, 8'h00);
         chk("hunt_hold", 16'(offset_o), 16'(off));
         tx(10'd0, 1'b0, 2'b00, 8'h00);
         off = (off + 1) % 10;
         chk("hunt_slip", 16'(offset_o), 16'(off));
         chk_quiet("hunt");
      end
   endtask

   task automatic acquire(input logic [3:0] off);
      logic [1:0] c = '0;
      chk_dec = 1'b0;
      for (int i = 0; i < 16; i++) begin
         c = 2'($urandom_range(0, 3));
         send_tok(c);
         chk("prelock", 16'(locked_o), 16'd0);
      end
      send_byte(8'($urandom_range(0, 255)));
      chk("lock_rise", 16'(locked_o), 16'd1);
      chk("lock_off",  16'(offset_o), 16'(off));
      chk("lock_ctrl", 16'(ctrl_o),   16'(c));
      chk("lock_de",   16'(de_o),     16'd0);
      chk("lock_data", 16'(data_o),   16'd0);
      exp_off = off;
      chk_dec = 1'b1;
   endtask

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) send_tok(2'($urandom_range(0, 3)));
         else                           send_byte(8'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_quiet("reset");
      chk("reset_off", 16'(offset_o), 16'd0);
      rst = 1'b0;

      // Run interruption at offset 0: 15 tokens, data, then 16 tokens
      set_delay(0);
      for (int i = 0; i < 15; i++) begin
         send_tok(2'b11);
         chk("run15", 16'(locked_o), 16'd0);
      end
      send_byte(8'h5A);
      chk("run_brk", 16'(locked_o), 16'd0);
      acquire(4'd0);

      // Direct words
      tx(10'b0100000000, 1'b0, 2'b00, 8'h00);
      tx(10'b1011111111, 1'b0, 2'b00, 8'hFE);
      tx(10'b0010101011, 1'b1, 2'b01, 8'h00);
      random_run(300);

      // Lock loss: a token, then 2048 data words
      send_tok(2'b10);
      for (int i = 0; i < 2048; i++) send_byte(8'($urandom_range(0, 255)));
      chk_dec = 1'b0;
      tx(10'd0, 1'b0, 2'b00, 8'h00);
      chk("loss_off", 16'(offset_o), 16'd1);
      chk_quiet("loss");

      // Hunt to offset 3, lock on a 3-bit delayed stream
      hunt(2, 1);
      set_delay(3);
      acquire(4'd3);
      random_run(200);

      // Reset mid-lock
      chk_dec = 1'b0;
      rst  = 1'b1;
      tmds = '0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      p_valid = 1'b0;
      chk_quiet("midrst");
      chk("midrst_off", 16'(offset_o), 16'd0);

      // Relock on a 7-bit delayed stream
      set_delay(0);
      hunt(7, 0);
      set_delay(7);
      acquire(4'd7);
      random_run(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
